i2c_req_arbiter: RTL and testbench
==================================

# i2c_req_arbiter

Round-robin arbiter and sequencer that shares one `i2c_master` instance between `NUM_REQ` independent requesters. It accepts level requests carrying address, direction and write byte. It grants one requester at a time and issues the single-cycle start pulse to the master. It waits for the master's done, captures read data, and returns a done/error pulse to the granted requester. It sits between the system-side command sources and the `i2c_master`, in the same `clk` domain.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 100_000: maximum `clk` cycles in WAIT before the transaction is abandoned.
- `GAP_CYCLES`, 4: idle `clk` cycles enforced after every transaction before the next grant.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, same clock as `i2c_master.clk`.
- `arst`  in  1  asynchronous active-high reset.
- `req`  in  NUM_REQ  level request per requester; held until that requester's `done` bit pulses.
- `req_addr`  in  7*NUM_REQ  7-bit slave address per requester; slice i = bits [7i+6:7i].
- `req_rw`  in  NUM_REQ  direction per requester; 1 = read.
- `req_wdata`  in  8*NUM_REQ  write byte per requester; slice i = bits [8i+7:8i].
- `gnt`  out  NUM_REQ  one-hot grant, high from START through DONE.
- `done`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `err`  out  1  high with `done` when the transaction timed out.
- `rdata`  out  8  captured read byte; valid when `done` pulses for a read; holds until the next capture.
- `busy`  out  1  high in every state except IDLE.
- `m_start`  out  1  to `i2c_master.i2c_start`; one-cycle pulse.
- `m_addr`  out  7  to `i2c_master.addr`.
- `m_rw`  out  1  to `i2c_master.rw`.
- `m_wdata`  out  8  to `i2c_master.data_send`.
- `m_done`  in  1  from `i2c_master.i2c_done`.
- `m_rdata`  in  8  from `i2c_master.data_recv`.
- `m_rdata_done`  in  1  from `i2c_master.data_recv_done`.

## Operation
- **States:** IDLE, START, WAIT, DONE, GAP.
- **IDLE:** if any `req` bit is high, select the winner by round-robin. The search starts at `ptr+1` and wraps modulo NUM_REQ. On selection:
  - register the one-hot `gnt`;
  - latch the winner's addr/rw/wdata into `m_addr`/`m_rw`/`m_wdata`;
  - go to START.
- **START (1 cycle):** `m_start`=1; go to WAIT. The timeout counter is cleared.
- **WAIT:**
  - the timeout counter increments each cycle;
  - on `m_rdata_done`, capture `m_rdata` into an internal register;
  - on `m_done`, go to DONE with `err`=0;
  - if the counter reaches TIMEOUT_CYCLES-1 without `m_done`, go to DONE with `err`=1;
  - if `m_done` and the timeout occur in the same cycle, `m_done` wins (`err`=0).
- **DONE (1 cycle):**
  - `done[i]`=1 for the granted i; `err` valid;
  - `rdata` is updated from the capture register if `m_rw`=1, and is unchanged for writes;
  - `ptr` is set to i;
  - go to GAP.
- **GAP:** count GAP_CYCLES cycles with `gnt`=0, then go to IDLE. If GAP_CYCLES=0, go to IDLE directly.
- **Request handling:**
  - a `req` deassertion after grant does not abort the transaction; `done` still pulses;
  - requester-side inputs are ignored after the latch;
  - there is no repeated-start chaining: each grant is exactly one I2C transaction.
- **Reset:** `arst` mid-transaction returns the block to IDLE immediately. The `i2c_master` must be reset by the same system reset.
- **Counter widths:** clog2(TIMEOUT_CYCLES) and clog2(GAP_CYCLES+1); counters never wrap.

## Timing
- **Reset values:**
  - `gnt`, `done`, `err`, `m_start`, `busy`, `m_rw` = 0;
  - `rdata`, `m_addr`, `m_wdata` = 0;
  - `ptr` = NUM_REQ-1, so requester 0 has priority first.
- **Grant latency:** `req` sampled high in IDLE at cycle N → `gnt` and `m_start` high at cycle N+1. `m_start` is high for exactly one cycle.
- **Done latency:** `m_done` at cycle M → `done` pulse at M+1, and `gnt` falls at M+2.
- **Back-to-back requests:** the minimum spacing between `m_start` pulses is 3+GAP_CYCLES cycles after `m_done`.
- **Simultaneous requests:** exactly one grant per IDLE→START transition. Losers stay pending and are served in rotation order.
- `m_addr`/`m_rw`/`m_wdata` are stable from START until the next START.

## Test plan
- **Single write:** `req`=0001, addr0=0x50, rw0=0, wdata0=0xA5. Expect:
  - `m_start` 1 cycle after `req`, with `m_addr`=0x50 and `m_wdata`=0xA5;
  - after the model raises `m_done`, `done`=0001 one cycle later with `err`=0.
- **Read:** `req`=0100, rw2=1; the model pulses `m_rdata_done` with `m_rdata`=0x3C and then `m_done`. Expect `done`=0100 and `rdata`=0x3C, with `rdata` still 0x3C during the next write transaction.
- **Round-robin:** `req`=1111 held after reset. Expect grant order 0,1,2,3,0, each separated by GAP_CYCLES idle cycles.
- **Timeout:** TIMEOUT_CYCLES=50 and the model never asserts `m_done`. Expect `done` with `err`=1 exactly 50 cycles after START; the next request is then served normally.
- **Tie:** `m_done` asserted in the timeout cycle → `err`=0.
- **Reset mid-WAIT:** assert `arst` while in WAIT. Expect all outputs at reset values immediately; after release, `req`=0010 is granted to requester 1, with no stale `done`.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ requesters.
// Grants one level request at a time and sequences start/done with the master.
module i2c_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int GAP_CYCLES     = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 m_start,
  output logic [6:0]           m_addr,
  output logic                 m_rw,
  output logic [7:0]           m_wdata,
  input  logic                 m_done,
  input  logic [7:0]           m_rdata,
  input  logic                 m_rdata_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW =
    (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GLAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  state_t state, state_n;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gidx;
  logic [TW-1:0]      tcnt;
  logic [GW-1:0]      gcnt;
  logic [7:0]         cap;
  logic [PW-1:0]      win;
  logic               found;
  int                 idx;
  logic [6:0]         sel_addr;
  logic               sel_rw;
  logic [7:0]         sel_wdata;
  logic [NUM_REQ-1:0] sel_oh;
  logic               tmo;
  logic               fin;

  // Search begins just after the last served requester.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_rw    = 1'b0;
    sel_wdata = '0;
    sel_oh    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PW'(i)) begin
        sel_addr  = req_addr[7*i +: 7];
        sel_rw    = req_rw[i];
        sel_wdata = req_wdata[8*i +: 8];
        sel_oh[i] = 1'b1;
      end
    end
  end

  assign tmo     = (tcnt >= TW'(TIMEOUT_CYCLES - 1));
  assign fin     = m_done || tmo;
  assign m_start = (state == S_START);
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (found) state_n = S_START;
      S_START: state_n = S_WAIT;
      S_WAIT:  if (fin) state_n = S_DONE;
      S_DONE:  state_n = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gcnt == GW'(GLAST)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      m_addr  <= '0;
      m_rw    <= 1'b0;
      m_wdata <= '0;
      ptr     <= PW'(NUM_REQ - 1);
      gidx    <= '0;
      tcnt    <= '0;
      gcnt    <= '0;
      cap     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (found) begin
            gnt     <= sel_oh;
            gidx    <= win;
            m_addr  <= sel_addr;
            m_rw    <= sel_rw;
            m_wdata <= sel_wdata;
            tcnt    <= '0;
          end
        end
        // The START cycle counts toward the timeout window.
        S_START: tcnt <= tcnt + 1'b1;
        S_WAIT: begin
          if (m_rdata_done) cap <= m_rdata;
          if (fin) begin
            done <= gnt;
            err  <= !m_done;
            if (m_rw) rdata <= m_rdata_done ? m_rdata : cap;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          done <= '0;
          err  <= 1'b0;
          gnt  <= '0;
          ptr  <= gidx;
          gcnt <= '0;
        end
        S_GAP: begin
          if (gcnt != GW'(GLAST)) gcnt <= gcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter with a behavioural i2c_master model.
// Start and done monitors pop expectations queued by the directed driver.
module tb_i2c_req_arbiter;

  localparam int N  = 4;
  localparam int TO = 50;
  localparam int G  = 4;

  logic           clk = 1'b0;
  logic           arst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [N-1:0]   req_rw = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           err;
  logic [7:0]     rdata;
  logic           busy;
  logic           m_start;
  logic [6:0]     m_addr;
  logic           m_rw;
  logic [7:0]     m_wdata;
  logic           m_done = 1'b0;
  logic [7:0]     m_rdata = '0;
  logic           m_rdata_done = 1'b0;

  i2c_req_arbiter #(
    .NUM_REQ(N), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(G)
  ) dut (
    .clk(clk), .arst(arst), .req(req), .req_addr(req_addr),
    .req_rw(req_rw), .req_wdata(req_wdata), .gnt(gnt),
    .done(done), .err(err), .rdata(rdata), .busy(busy),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw),
    .m_wdata(m_wdata), .m_done(m_done), .m_rdata(m_rdata),
    .m_rdata_done(m_rdata_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    int         exp_start;
    int         delta;
  } st_t;

  typedef struct {
    int         idx;
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } dn_t;

  st_t sq[$];
  dn_t dq[$];

  int ncmp = 0;
  int nfail = 0;
  int md_at = 1;
  int mrd_at = 0;
  logic [7:0] mbyte = '0;
  logic [7:0] rmodel = '0;
  int n_done = 0;
  int last_start = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // i2c_master model: done after md_at cycles, never when md_at is 0.
  initial begin
    forever begin
      @(negedge clk);
      if (m_start === 1'b1 && !arst) begin
        for (int k = 1; k <= TO + 1; k++) begin
          @(negedge clk);
          if (arst) break;
          m_rdata_done = (mrd_at == k);
          m_rdata = (mrd_at == k) ? mbyte : 8'h00;
          m_done = (md_at == k);
          if (md_at == k) break;
        end
        @(negedge clk);
        m_done = 1'b0;
        m_rdata_done = 1'b0;
      end
    end
  end

  initial begin
    st_t e;
    forever begin
      @(negedge clk);
      if (m_start === 1'b1) begin
        if (sq.size() == 0) begin
          chk("unexpected_start", 32'(m_start), 32'd0);
        end else begin
          e = sq.pop_front();
          chk("start_gnt", 32'(gnt), 32'd1 << e.idx);
          chk("start_addr", 32'(m_addr), 32'(e.addr));
          chk("start_rw", 32'(m_rw), 32'(e.rw));
          chk("start_wdata", 32'(m_wdata), 32'(e.wdata));
          if (e.exp_start >= 0)
            chk("start_cycle", cyc, e.exp_start);
          if (e.delta >= 0)
            chk("start_spacing", cyc - last_start, e.delta);
        end
        last_start = cyc;
        @(negedge clk);
        chk("start_width", 32'(m_start), 32'd0);
      end
    end
  end

  initial begin
    dn_t d;
    forever begin
      @(negedge clk);
      if (done !== '0) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          d = dq.pop_front();
          chk("done_vec", 32'(done), 32'd1 << d.idx);
          chk("done_err", 32'(err), 32'(d.err));
          chk("done_rdata", 32'(rdata), 32'(d.rdata));
          chk("done_latency", cyc - last_start, d.lat);
          chk("done_gnt", 32'(gnt), 32'd1 << d.idx);
        end
        n_done++;
        @(negedge clk);
        chk("gnt_release", 32'(gnt), 32'd0);
      end
    end
  end

  task automatic set_req(input int i, input logic rw,
                         input logic [6:0] a, input logic [7:0] w);
    req_rw[i] = rw;
    req_addr[7*i +: 7] = a;
    req_wdata[8*i +: 8] = w;
  endtask

  task automatic wait_dones(input int target, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 32'(n_done), 32'(target));
  endtask

  task automatic single(input int i, input logic rw,
                        input logic [6:0] a, input logic [7:0] w,
                        input int dat, input int rdat,
                        input logic [7:0] rb, input logic e,
                        input int lat);
    int t;
    t = n_done + 1;
    md_at = dat;
    mrd_at = rdat;
    mbyte = rb;
    @(negedge clk);
    set_req(i, rw, a, w);
    if (rw) rmodel = rb;
    sq.push_back('{i, rw, a, w, cyc + 1, -1});
    dq.push_back('{i, e, rmodel, lat});
    req[i] = 1'b1;
    wait_dones(t, 200);
    req[i] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_m_start", 32'(m_start), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_m_bus", {m_rw, m_addr, m_wdata}, 32'd0);
    arst = 1'b0;
    repeat (2) @(negedge clk);

    // All four requesting: rotation 0,1,2,3,0.
    md_at = 3;
    mrd_at = 0;
    t = n_done + 5;
    for (int i = 0; i < N; i++)
      set_req(i, 1'b0, 7'(8'h10 + i), 8'(8'hC0 + i));
    sq.push_back('{0, 1'b0, 7'h10, 8'hC0, cyc + 1, -1});
    for (int i = 1; i <= 4; i++)
      sq.push_back('{i % N, 1'b0, 7'(8'h10 + (i % N)),
                     8'(8'hC0 + (i % N)), -1, 3 + 3 + G});
    for (int i = 0; i <= 4; i++)
      dq.push_back('{i % N, 1'b0, rmodel, 4});
    req = '1;
    wait_dones(t, 300);
    req = '0;
    repeat (8) @(negedge clk);

    single(0, 1'b0, 7'h50, 8'hA5, 4, 0, 8'h00, 1'b0, 5);
    single(2, 1'b1, 7'h48, 8'h00, 5, 2, 8'h3C, 1'b0, 6);
    single(1, 1'b0, 7'h21, 8'h99, 2, 0, 8'h00, 1'b0, 3);
    single(3, 1'b0, 7'h11, 8'h22, 0, 0, 8'h00, 1'b1, TO);
    single(0, 1'b0, 7'h55, 8'h66, 4, 0, 8'h00, 1'b0, 5);
    single(2, 1'b0, 7'h0F, 8'hF0, TO - 1, 0, 8'h00, 1'b0, TO);

    // Reset while the master is still busy.
    md_at = 0;
    mrd_at = 0;
    @(negedge clk);
    set_req(3, 1'b1, 7'h33, 8'h44);
    sq.push_back('{3, 1'b1, 7'h33, 8'h44, cyc + 1, -1});
    req[3] = 1'b1;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    arst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_outs", {done, err, m_start, m_rw}, 32'd0);
    chk("arst_data", {m_addr, m_wdata, rdata}, 32'd0);
    rmodel = '0;
    req = '0;
    repeat (3) @(negedge clk);
    arst = 1'b0;
    repeat (2) @(negedge clk);
    single(1, 1'b0, 7'h2A, 8'h5E, 4, 0, 8'h00, 1'b0, 5);

    repeat (5) @(negedge clk);
    chk("start_queue_empty", 32'(sq.size()), 32'd0);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
